des_round_ctrl: RTL and testbench

Sequencing controller for the iterative DES datapath: accepts one block per start/ready handshake and drives the load, S-box issue, round commit and final-permutation enables for 16 rounds. It also supplies the key-schedule round index and shift amounts. The S-box stage (s1..s8) registers its output, so every round waits SBOX_LAT cycles before committing. Sits between the host-side block interface and the Feistel datapath/key register.

---
 rtl/des_pkg.sv | 28 ++
 rtl/des_round_ctrl_if.sv | 31 +++
 rtl/des_key_shift_lut.sv | 15 +
 rtl/des_round_ctrl.sv | 104 ++++++++++
 tb/tb_des_round_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared definitions for the DES round controller and the key-schedule block.
//   state_e    : controller FSM states
//   DES_ROUNDS : number of Feistel rounds
//   ENC_SHIFT  : per-round C/D rotate amount, encrypt (index = round)
//   DEC_SHIFT  : per-round C/D rotate amount, decrypt (round 0 uses the PC1 value directly)
//   shift_for  : table lookup by round index and direction
package des_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StFinal,
    StDone
  } state_e;

  localparam int unsigned DES_ROUNDS = 16;

  // Element 0 is the rightmost entry.
  localparam logic [15:0][1:0] ENC_SHIFT = {2'd1, {6{2'd2}}, 2'd1, {6{2'd2}}, 2'd1, 2'd1};
  localparam logic [15:0][1:0] DEC_SHIFT = {2'd1, {6{2'd2}}, 2'd1, {6{2'd2}}, 2'd1, 2'd0};

  function automatic logic [1:0] shift_for(input logic [3:0] idx, input logic dir);
    return dir ? DEC_SHIFT[idx] : ENC_SHIFT[idx];
  endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// Host/datapath handshake bundle of the DES round controller.
//   master : drives start, decrypt, abort, out_ready; observes status and enables
//   slave  : the controller side
interface des_round_ctrl_if;
  logic       start;
  logic       decrypt;
  logic       abort;
  logic       out_ready;
  logic       ready;
  logic       busy;
  logic       load_en;
  logic       sbox_issue;
  logic       round_commit;
  logic       final_en;
  logic       out_valid;
  logic [3:0] round_idx;
  logic [1:0] key_shift;
  logic       key_dir;

  modport master (
    output start, decrypt, abort, out_ready,
    input  ready, busy, load_en, sbox_issue, round_commit, final_en, out_valid,
    input  round_idx, key_shift, key_dir
  );

  modport slave (
    input  start, decrypt, abort, out_ready,
    output ready, busy, load_en, sbox_issue, round_commit, final_en, out_valid,
    output round_idx, key_shift, key_dir
  );
endinterface

// File: rtl/des_key_shift_lut.sv
// Combinational key-schedule rotate lookup.
//   i_round_idx : round 0..15
//   i_key_dir   : 0 = encrypt (rotate left), 1 = decrypt (rotate right)
//   o_key_shift : rotate amount 0..2
module des_key_shift_lut
  import des_pkg::*;
(
  input  logic [3:0] i_round_idx,
  input  logic       i_key_dir,
  output logic [1:0] o_key_shift
);

  assign o_key_shift = shift_for(i_round_idx, i_key_dir);

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencing controller for the iterative DES datapath.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of des_round_ctrl_if (start/decrypt/abort/out_ready in;
//         ready, busy, enable pulses, out_valid, round_idx, key_shift, key_dir out)
// Every output is a decode of registered state, so there is no input-to-output path.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 1  // legal 1..4
) (
  input  logic           clk,
  input  logic           rst,
  des_round_ctrl_if.slave bus
);

  localparam logic [1:0] LatInit   = 2'(SBOX_LAT - 1);
  localparam logic [3:0] LastRound = 4'(DES_ROUNDS - 1);

  state_e     r_state, w_state_d;
  logic [3:0] r_round, w_round_d;
  logic [1:0] r_lat,   w_lat_d;
  logic       r_dir,   w_dir_d;
  logic [1:0] w_lut_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_round <= 4'd0;
      r_lat   <= 2'd0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_round <= w_round_d;
      r_lat   <= w_lat_d;
      r_dir   <= w_dir_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_round_d = r_round;
    w_lat_d   = r_lat;
    w_dir_d   = r_dir;
    if (bus.abort) begin
      // Abort beats everything, including a start in IDLE.
      w_state_d = StIdle;
      w_round_d = 4'd0;
      w_lat_d   = 2'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            w_state_d = StLoad;
            w_dir_d   = bus.decrypt;
            w_round_d = 4'd0;
          end
        end
        StLoad:  w_state_d = StIssue;
        StIssue: begin
          w_lat_d   = LatInit;
          w_state_d = StWait;
        end
        StWait: begin
          if (r_lat == 2'd0) begin
            if (r_round == LastRound) begin
              w_state_d = StFinal;
            end else begin
              w_round_d = r_round + 4'd1;
              w_state_d = StIssue;
            end
          end else begin
            w_lat_d = r_lat - 2'd1;
          end
        end
        StFinal: w_state_d = StDone;
        StDone: begin
          // ready is low here, so a coincident start is dropped.
          if (bus.out_ready) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  des_key_shift_lut u_lut (
    .i_round_idx (r_round),
    .i_key_dir   (r_dir),
    .o_key_shift (w_lut_shift)
  );

  assign bus.ready        = (r_state == StIdle);
  assign bus.busy         = (r_state == StLoad) || (r_state == StIssue) ||
                            (r_state == StWait) || (r_state == StFinal);
  assign bus.load_en      = (r_state == StLoad);
  assign bus.sbox_issue   = (r_state == StIssue);
  assign bus.round_commit = (r_state == StWait) && (r_lat == 2'd0);
  assign bus.final_en     = (r_state == StFinal);
  assign bus.out_valid    = (r_state == StDone);
  assign bus.round_idx    = r_round;
  assign bus.key_shift    = (r_state == StIssue) ? w_lut_shift : 2'd0;
  assign bus.key_dir      = r_dir;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: one instance with SBOX_LAT=1, one with SBOX_LAT=3,
// selected by sel. Every observed output is packed as
// {load, issue, commit, final, valid, busy, ready, dir, idx[3:0], shift[1:0]}.
module tb_des_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic start = 1'b0, decrypt = 1'b0, abort = 1'b0, out_ready = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  des_round_ctrl_if if1 ();
  des_round_ctrl_if if3 ();

  assign if1.start     = start & ~sel;
  assign if1.decrypt   = decrypt;
  assign if1.abort     = abort & ~sel;
  assign if1.out_ready = out_ready & ~sel;
  assign if3.start     = start & sel;
  assign if3.decrypt   = decrypt;
  assign if3.abort     = abort & sel;
  assign if3.out_ready = out_ready & sel;

  des_round_ctrl #(.SBOX_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  des_round_ctrl #(.SBOX_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  logic [13:0] obs1, obs3, obs;
  assign obs1 = {if1.load_en, if1.sbox_issue, if1.round_commit, if1.final_en, if1.out_valid,
                 if1.busy, if1.ready, if1.key_dir, if1.round_idx, if1.key_shift};
  assign obs3 = {if3.load_en, if3.sbox_issue, if3.round_commit, if3.final_en, if3.out_valid,
                 if3.busy, if3.ready, if3.key_dir, if3.round_idx, if3.key_shift};
  assign obs  = sel ? obs3 : obs1;

  // Hand-written from the DES key schedule.
  int enc_tbl [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_tbl [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [13:0] RstVec  = 14'b0000001_0_0000_00;  // only ready high
  localparam logic [13:0] IdleMsk = 14'b1111111_0_0000_11;  // ignore dir and idx

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] pack(input bit ld, is, cm, fn, vl, bz, rd, dir,
                                       input int idx, input int sh);
    logic [3:0] i4;
    logic [1:0] s2;
    i4 = 4'(idx);
    s2 = 2'(sh);
    return {ld, is, cm, fn, vl, bz, rd, dir, i4, s2};
  endfunction

  // One block; optional abort or reset after the check of cycle abort_at / rst_at,
  // optional hold cycles in DONE with start pulsing before out_ready.
  task automatic do_block(input bit dec, input int abort_at, input int rst_at, input int hold);
    int lat, per, cf, cv, r, sh;
    bit is, cm;
    lat = sel ? 3 : 1;
    per = lat + 1;
    cf  = 2 + 16 * per;
    cv  = cf + 1;
    @(negedge clk);
    check_eq("ready_before_start", 32'(obs[7]), 32'd1);
    start   = 1'b1;
    decrypt = dec;
    @(posedge clk);  // edge T
    for (int c = 1; c <= cv; c++) begin
      @(negedge clk);
      start = 1'b0;
      r = (c < 2) ? 0 : (c - 2) / per;
      if (r > 15) r = 15;
      is = (c >= 2) && (c < cf) && ((c - 2) % per == 0);
      cm = (c >= 2 + lat) && (c < cf) && ((c - 2 - lat) % per == 0);
      sh = is ? (dec ? dec_tbl[r] : enc_tbl[r]) : 0;
      check_eq($sformatf("lat%0d dec%0d c%0d", lat, dec, c), 32'(obs),
               32'(pack(c == 1, is, cm, c == cf, c == cv, (c >= 1) && (c <= cf), 1'b0, dec,
                        r, sh)));
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_to_idle", 32'(obs & IdleMsk), 32'(RstVec));
        for (int k = 0; k < 3 * per; k++) begin
          @(negedge clk);
          check_eq($sformatf("post_abort k%0d", k), 32'(obs & IdleMsk), 32'(RstVec));
        end
        return;
      end
      if (c == rst_at) begin
        #2 rst = 1'b1;
        #1 check_eq("async_rst", 32'(obs), 32'(RstVec));
        @(negedge clk);
        rst = 1'b0;
        check_eq("after_rst", 32'(obs), 32'(RstVec));
        return;
      end
    end
    // DONE: hold with start pulsing, then out_ready together with start.
    start = (hold > 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      start = ~start;
      check_eq($sformatf("done_hold k%0d", k), 32'(obs[13:7]), 32'(7'b0000100));
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check_eq("done_to_idle", 32'(obs[13:7]), 32'(7'b0000001));
    @(negedge clk);
    check_eq("start_in_done_dropped", 32'(obs[13:7]), 32'(7'b0000001));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset_lat1", 32'(obs1), 32'(RstVec));
    check_eq("reset_lat3", 32'(obs3), 32'(RstVec));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("idle k%0d", k), 32'(obs), 32'(RstVec));
    end
    sel = 1'b0;
    do_block(1'b0, 0, 0, 0);   // encrypt, SBOX_LAT=1
    sel = 1'b1;
    do_block(1'b1, 0, 0, 10);  // decrypt, SBOX_LAT=3, held in DONE
    do_block(1'b0, 31, 0, 0);  // abort in round 7 WAIT
    do_block(1'b0, 0, 0, 0);   // fresh start after abort
    sel = 1'b0;
    do_block(1'b1, 0, 9, 0);   // reset during round 3
    do_block(1'b1, 0, 0, 0);   // complete block after reset
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
